// File: rtl/pacman_dl_ctrl_if.sv
// pacman_dl_ctrl_if
// Groups the HPS ioctl download stream and the ROM write bus that the
// controller drives into the Pacman core.
//   master : HPS/stimulus side; drives ioctl_*, observes dn_*
//   slave  : controller side; consumes ioctl_*, drives dn_*
// Signals:
//   ioctl_download  download window active
//   ioctl_index     download target (0 ROM, 1 MOD, 254 DIP)
//   ioctl_wr        one-cycle write strobe
//   ioctl_addr      byte address within the download
//   ioctl_dout      write data
//   dn_addr/dn_data/dn_wr  ROM write port toward the core
interface pacman_dl_ctrl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr
    );
endinterface

// File: rtl/pacman_dl_ctrl.sv
// pacman_dl_ctrl
// Download and reset sequencer between the HPS ioctl stream and the Pacman
// core. ROM bytes (index 0) are forwarded on the dn_* bus, the variant byte
// (index 1) and DIP bytes (index 254) are latched, and core_reset is held
// until a ROM is present and for HOLD_CYCLES after each ROM/MOD load or
// user reset.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   io           ioctl stream in, ROM write bus out (slave modport)
//   user_reset   level, OSD reset or button
//   core_reset   core reset, active high
//   mod          latched variant byte
//   sw_bus       DIP bytes, byte n at [8n+7:8n]
//   rom_loaded   at least one ROM download completed
//   addr_ovf     sticky: a ROM write addressed >= 0x10000
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no ROM yet (or after RESET); core held in reset
// LOAD_ROM | ROM download window open; core held in reset
// LOAD_MOD | variant download window open; core held in reset
// LOAD_DIP | DIP download window open; core_reset unchanged
// LOAD_X   | download to an unused index; core_reset unchanged
// HOLD     | settle period, down-counter running; core held in reset
// RUN      | core released
module pacman_dl_ctrl #(
    parameter int HOLD_CYCLES = 64
) (
    input  logic                   CLK,
    input  logic                   RESET,
    pacman_dl_ctrl_if.slave        io,
    input  logic                   user_reset,
    output logic                   core_reset,
    output logic [7:0]             mod,
    output logic [63:0]            sw_bus,
    output logic                   rom_loaded,
    output logic                   addr_ovf
);

    localparam logic [15:0] HOLD_RELOAD = 16'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_ROM,
        S_LOAD_MOD,
        S_LOAD_DIP,
        S_LOAD_X,
        S_HOLD,
        S_RUN
    } state_t;

    state_t      state, state_nxt;
    state_t      saved, saved_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic        core_reset_nxt;
    logic        rom_loaded_nxt;
    logic        dl_d;
    logic        dl_rise;
    logic        dl_fall;

    assign dl_rise = io.ioctl_download & ~dl_d;
    assign dl_fall = ~io.ioctl_download & dl_d;

    // dl_d keeps tracking through RESET so a reset inside a download
    // window does not produce a fresh rise once RESET drops.
    always_ff @(posedge CLK) begin
        dl_d <= io.ioctl_download;
        if (RESET) begin
            state      <= S_IDLE;
            saved      <= S_IDLE;
            cnt        <= '0;
            core_reset <= 1'b1;
            rom_loaded <= 1'b0;
        end else begin
            state      <= state_nxt;
            saved      <= saved_nxt;
            cnt        <= cnt_nxt;
            core_reset <= core_reset_nxt;
            rom_loaded <= rom_loaded_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        saved_nxt      = saved;
        cnt_nxt        = cnt;
        core_reset_nxt = core_reset;
        rom_loaded_nxt = rom_loaded;

        if (dl_rise) begin
            saved_nxt = state;
            case (io.ioctl_index)
                8'd0: begin
                    state_nxt      = S_LOAD_ROM;
                    core_reset_nxt = 1'b1;
                end
                8'd1: begin
                    state_nxt      = S_LOAD_MOD;
                    core_reset_nxt = 1'b1;
                end
                8'd254:  state_nxt = S_LOAD_DIP;
                default: state_nxt = S_LOAD_X;
            endcase
        end else begin
            case (state)
                S_LOAD_ROM: begin
                    if (dl_fall) begin
                        rom_loaded_nxt = 1'b1;
                        state_nxt      = S_HOLD;
                        cnt_nxt        = HOLD_RELOAD;
                    end
                end
                S_LOAD_MOD: begin
                    if (dl_fall) begin
                        if (rom_loaded) begin
                            state_nxt = S_HOLD;
                            cnt_nxt   = HOLD_RELOAD;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                // counter is left untouched so a HOLD interrupted by a
                // DIP download resumes where it stopped
                S_LOAD_DIP, S_LOAD_X: begin
                    if (dl_fall) begin
                        state_nxt = saved;
                    end
                end
                S_HOLD: begin
                    if (user_reset) begin
                        cnt_nxt = HOLD_RELOAD;
                    end else if (cnt == 16'd0) begin
                        state_nxt      = S_RUN;
                        core_reset_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt - 16'd1;
                    end
                end
                S_RUN: begin
                    if (user_reset) begin
                        state_nxt      = S_HOLD;
                        cnt_nxt        = HOLD_RELOAD;
                        core_reset_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Write routing follows the live index, independent of the FSM state,
    // so writes after a mid-window RESET are still delivered.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            io.dn_wr   <= 1'b0;
            io.dn_addr <= '0;
            io.dn_data <= '0;
            mod        <= '0;
            sw_bus     <= '1;
            addr_ovf   <= 1'b0;
        end else begin
            io.dn_wr <= 1'b0;
            if (io.ioctl_download && io.ioctl_wr) begin
                case (io.ioctl_index)
                    8'd0: begin
                        if (io.ioctl_addr[24:16] == 9'd0) begin
                            io.dn_addr <= io.ioctl_addr[15:0];
                            io.dn_data <= io.ioctl_dout;
                            io.dn_wr   <= 1'b1;
                        end else begin
                            addr_ovf <= 1'b1;
                        end
                    end
                    8'd1: begin
                        if (io.ioctl_addr == 25'd0) begin
                            mod <= io.ioctl_dout;
                        end
                    end
                    8'd254: begin
                        if (io.ioctl_addr < 25'd8) begin
                            sw_bus[{io.ioctl_addr[2:0], 3'b000} +: 8] <= io.ioctl_dout;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/pacman_dl_ctrl.md
# pacman_dl_ctrl

Download and reset sequencer between the HPS ioctl stream and the Pacman core. It routes ROM bytes (index 0) onto the core's download bus, latches the game-variant byte (index 1) and the eight DIP bytes (index 254), and owns the core reset. The core is held in reset until a ROM image is present and for a fixed settle period after every ROM or variant load or user reset.

## Interface
Parameters:
- HOLD_CYCLES, 64: cycles core_reset is held after a ROM/MOD download ends or a user reset; legal range 1..65535.

Ports:
- CLK  in  1  system clock (clk_sys domain).
- RESET  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  download target: 0 ROM, 1 MOD, 254 DIP, others ignored.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address within the download.
- ioctl_dout  in  8  write data.
- user_reset  in  1  level; OSD reset or button.
- dn_addr  out  16  ROM write address to core.
- dn_data  out  8  ROM write data to core.
- dn_wr  out  1  ROM write strobe to core.
- core_reset  out  1  core reset, active high.
- mod  out  8  latched variant byte.
- sw_bus  out  64  DIP bytes; byte n is at [8n+7:8n].
- rom_loaded  out  1  at least one ROM download has completed.
- addr_ovf  out  1  sticky flag: a ROM write addressed ≥ 0x10000.

## Operation
- States: IDLE, LOAD_ROM, LOAD_MOD, LOAD_DIP, LOAD_X, HOLD, RUN.
- Reset values: state IDLE, core_reset=1, dn_wr=0, dn_addr=0, dn_data=0, mod=0, sw_bus=all ones, rom_loaded=0, addr_ovf=0, hold counter=0.
- Rise of ioctl_download (registered dl_d=0, ioctl_download=1) in any state goes to LOAD_ROM, LOAD_MOD, LOAD_DIP or LOAD_X according to ioctl_index in that cycle. The prior state is saved for DIP/X return.
- LOAD_ROM, LOAD_MOD: core_reset=1. LOAD_DIP, LOAD_X: core_reset keeps its prior value.
- Writes are accepted only when ioctl_download=1 and ioctl_wr=1. Routing uses the live ioctl_index:
  - Index 0, addr[24:16]==0: dn_addr<=addr[15:0], dn_data<=dout, dn_wr<=1 for one cycle.
  - Index 0, addr[24:16]!=0: write dropped; addr_ovf<=1.
  - Index 1, addr==0: mod<=dout. Other addresses are ignored.
  - Index 254, addr<8: sw_bus byte addr<=dout. Other addresses are ignored.
  - Any other index: ignored.
- Fall of ioctl_download:
  - LOAD_ROM: rom_loaded<=1; go to HOLD; counter<=HOLD_CYCLES-1.
  - LOAD_MOD: go to HOLD if rom_loaded, else IDLE.
  - LOAD_DIP, LOAD_X: return to the saved state. If the saved state is HOLD, the counter resumes where it stopped.
- HOLD: core_reset=1. The counter decrements each cycle; when it reads 0, go to RUN and core_reset<=0.
- RUN: core_reset=0. user_reset=1 goes to HOLD with counter<=HOLD_CYCLES-1.
- HOLD with user_reset=1: counter reloads to HOLD_CYCLES-1 every cycle it is high.
- IDLE: user_reset is ignored; core_reset stays 1.
- Priority in one cycle: RESET > download edge > user_reset > counter.
- RESET mid-download: return to reset values immediately. Later writes in the same window are still routed by index, but no state transition occurs until the next download rise.

## Timing
- dn_wr, dn_addr, dn_data, mod and sw_bus update one cycle after the accepted ioctl_wr cycle.
- dn_wr is never high for two consecutive cycles unless ioctl_wr was.
- core_reset rises one cycle after the ioctl_download rise sample for ROM/MOD.
- After the ioctl_download fall, core_reset stays 1 for exactly HOLD_CYCLES cycles and then drops.
- After user_reset deasserts in RUN/HOLD, core_reset drops HOLD_CYCLES cycles after the last cycle user_reset was high.
- A write on the same cycle as the download rise is accepted.
- A write on the same cycle as the fall is not accepted, because ioctl_download=0.

## Test plan
- Reset, then idle for 1000 cycles -> core_reset=1, rom_loaded=0, sw_bus=0xFFFF_FFFF_FFFF_FFFF, dn_wr never pulses.
- ROM download of 3 bytes (0x0000=0xAA, 0x0001=0x55, 0x3FFF=0x12), HOLD_CYCLES=64 -> three dn_wr pulses, each one cycle after its ioctl_wr, with matching addr/data. rom_loaded=1 after the fall. core_reset falls exactly 64 cycles after the fall.
- ROM write at 0x10000 -> no dn_wr, addr_ovf=1 and sticky across a later valid download.
- In RUN: DIP download (addr 2=0x7F), then MOD download (addr 0=0x05, addr 1=0x09):
  - DIP: core_reset stays 0 throughout; sw_bus[23:16]=0x7F.
  - MOD: mod=0x05 (addr 1 ignored); core_reset=1 during MOD and for 64 cycles after.
- In RUN: user_reset high for 10 cycles -> core_reset=1 from the next cycle until 64 cycles after user_reset falls. user_reset in IDLE has no effect.
- RESET asserted mid-ROM-download after 2 writes -> all outputs return to reset values next cycle; rom_loaded stays 0 after the window ends; core_reset stays 1.
